rv_mem_arbiter: RTL and testbench
=================================

# rv_mem_arbiter

Two-port to one-port memory arbiter that lets the core's instruction-fetch port and data port share a single memory instance. It sits between the core's IMem*/DMem* request ports and one memory's Mem* port, serialising transactions with one outstanding access at a time. It selects requesters by fixed or round-robin priority, latches the winning request, and routes responses back only to the granted requester. A watchdog terminates transactions the memory never answers.

## Interface
- ROUND_ROBIN, 0: 0 = data port always wins a tie; 1 = alternate on ties, starting from the data port.
- TIMEOUT, 255: cycles allowed from grant to MemData_rsp before abort; legal range 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on abort.
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- IMemAddress_vld / IMemAddress  in  1 / 32  fetch request and its address; the fetch port is always a read of size 2'b11.
- IMemAddress_rsp  out  1  fetch request accepted (1-cycle pulse).
- IMemData_rsp / IMemReadData  out  1 / 32  fetch data returned (pulse) and the fetched word.
- DMemAddress_vld / DMemAddress  in  1 / 32  data request and its address.
- DMemOp / DMemOpSize  in  1 / 2  operation (1 = write) and access size.
- DMemWData_vld / DMemWriteData  in  1 / 32  write data; must be valid together with DMemAddress_vld on writes.
- DMemAddress_rsp  out  1  data request accepted (pulse).
- DMemData_rsp / DMemReadData  out  1 / 32  data response (pulse) and read data.
- MemAddress_vld / MemAddress / MemOp / MemOpSize  out  1/32/1/2  request to the shared memory.
- MemWData_vld / MemWriteData  out  1 / 32  write data to the memory.
- MemAddress_rsp, MemData_rsp / MemReadData  in  1, 1 / 32  memory responses.
- bus_err  out  1  one-cycle pulse when a transaction is aborted by the watchdog.
- err_addr  out  32  address of the last aborted transaction; holds until the next abort.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - Samples IMemAddress_vld and DMemAddress_vld.
  - If either is set, picks the winner, latches address, op, size and write data into output registers, records the grant, clears the watchdog and goes to ADDR.
  - Fetch requests are latched as op 0, size 2'b11, wdata 0, MemWData_vld 0.
- Arbitration:
  - A single requester always wins.
  - With both requesting and ROUND_ROBIN=0, the data port wins.
  - With both requesting and ROUND_ROBIN=1, the port not granted last wins; last_grant resets to "fetch", so the data port wins the first tie.
- ADDR:
  - MemAddress_vld=1 with the latched fields held stable.
  - On MemAddress_rsp: drop MemAddress_vld and MemWData_vld and go to DATA.
  - If MemAddress_rsp and MemData_rsp arrive in the same cycle, the transaction completes directly and the state returns to IDLE.
- DATA: wait for MemData_rsp, then return to IDLE.
- Response routing:
  - Combinational, gated by the grant: Xmem_Address_rsp = MemAddress_rsp & granted(X) & (state==ADDR), and likewise for the data response.
  - The non-granted port sees rsp=0 and ReadData=0.
  - The granted port's ReadData equals MemReadData only while its Data_rsp is high, and 0 otherwise.
- Requesters deassert Address_vld the cycle after seeing Address_rsp. vld is only sampled in IDLE, so a vld seen there is always a new request.
- Watchdog:
  - A 16-bit counter increments every cycle in ADDR/DATA.
  - When it reaches TIMEOUT with no MemData_rsp, the block forces the granted port's Address_rsp (only if still in ADDR) and Data_rsp high for one cycle, with ReadData=ERR_DATA.
  - In the same cycle it pulses bus_err, loads err_addr, drops all Mem* request outputs and goes to IDLE.
  - If MemData_rsp arrives in the same cycle as expiry, normal completion wins and no error is raised.
- Addresses pass through untranslated; any base offset is applied outside this block.

## Timing
- Reset values: all outputs 0, err_addr=0, state=IDLE, last_grant=fetch, counter=0.
- rst asserted mid-transaction: the transaction is abandoned and all outputs are 0 on the next edge. Nothing is replayed after reset.
- Grant latency: request seen in IDLE at edge N → MemAddress_vld=1 from cycle N+1.
- Overhead: one IDLE cycle per transaction. The minimum period is 2 cycles plus memory latency.
- Back-to-back: the cycle after a Data_rsp is IDLE and may grant again.
- With ROUND_ROBIN=1 and both ports continuously requesting, grants strictly alternate D, I, D, I.
- Fetch starvation is possible only when ROUND_ROBIN=0.

## Test plan
- Single fetch: IMemAddress_vld, addr 0x0000_0040, memory answers with 2-cycle latency and data 0x0000_0013 → MemAddress_vld rises 1 cycle after the request, IMemData_rsp pulses with IMemReadData=0x0000_0013, and DMem* outputs stay 0.
- Data write: DMemOp=1, size 2'b10, addr 0x1010, wdata 0xCAFE_F00D → memory sees exactly those fields with MemWData_vld=1 until MemAddress_rsp; DMemData_rsp pulses once.
- Simultaneous requests, ROUND_ROBIN=0, both held for 4 transactions → 4 data grants and 0 fetch grants. Repeat with ROUND_ROBIN=1 → order D, I, D, I.
- Timeout with TIMEOUT=8: the memory never raises MemData_rsp on fetch addr 0x200 → exactly 8 cycles after grant, IMemData_rsp=1, IMemReadData=0xDEAD_BEEF, bus_err=1 for one cycle, err_addr=0x200, and the next request is granted normally.
- Memory returns MemAddress_rsp and MemData_rsp in the same cycle → the requester sees both pulses in that cycle and the state returns to IDLE the next cycle.
- rst pulsed for one cycle while in DATA → all outputs 0 the next cycle, the late MemData_rsp is ignored, and a fresh request after reset completes correctly.

Source files
------------

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: lets the instruction-fetch port and the data port of a core
// share one memory. One transaction is outstanding at a time. Responses are
// steered back only to the port that was granted. A watchdog aborts any
// transaction the memory leaves unanswered.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no transaction; sample both requests and grant one
//   ADDR  | request presented to memory, waiting for MemAddress_rsp
//   DATA  | address accepted, waiting for MemData_rsp
module rv_mem_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b0,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch requester
  input  logic        IMemAddress_vld,
  input  logic [31:0] IMemAddress,
  output logic        IMemAddress_rsp,
  output logic        IMemData_rsp,
  output logic [31:0] IMemReadData,
  // data requester
  input  logic        DMemAddress_vld,
  input  logic [31:0] DMemAddress,
  input  logic        DMemOp,
  input  logic [1:0]  DMemOpSize,
  input  logic        DMemWData_vld,
  input  logic [31:0] DMemWriteData,
  output logic        DMemAddress_rsp,
  output logic        DMemData_rsp,
  output logic [31:0] DMemReadData,
  // shared memory
  output logic        MemAddress_vld,
  output logic [31:0] MemAddress,
  output logic        MemOp,
  output logic [1:0]  MemOpSize,
  output logic        MemWData_vld,
  output logic [31:0] MemWriteData,
  input  logic        MemAddress_rsp,
  input  logic        MemData_rsp,
  input  logic [31:0] MemReadData,
  // watchdog reporting
  output logic        bus_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  // Everything presented to the memory is held in one register so it can be
  // latched at grant and cleared as a unit when the transaction ends.
  typedef struct packed {
    logic        vld;
    logic [31:0] addr;
    logic        op;
    logic [1:0]  size;
    logic        wvld;
    logic [31:0] wdata;
  } mem_req_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [1:0]  FETCH_SIZE  = 2'b11;

  state_t      state;
  mem_req_t    req_q;
  logic        grant_d;       // 1: data port owns the current transaction
  logic        last_grant_d;  // 1: data port won the previous grant
  logic [15:0] wdog;
  logic [31:0] err_addr_q;

  logic        busy;
  logic        any_req;
  logic        pick_d;
  logic        data_done;
  logic        expire;
  logic        addr_ack;
  logic        resp;
  logic [31:0] rsp_data;
  logic        sel_i;
  logic        sel_d;

  assign busy    = (state != IDLE);
  assign any_req = IMemAddress_vld | DMemAddress_vld;

  // Data wins a tie unless round-robin is on and data had the last grant.
  assign pick_d = DMemAddress_vld &
                  (~IMemAddress_vld | ~ROUND_ROBIN | ~last_grant_d);

  // A data response only counts once the address has been (or is being)
  // accepted; a stray MemData_rsp in ADDR on its own is ignored.
  assign data_done = ((state == DATA) & MemData_rsp) |
                     ((state == ADDR) & MemAddress_rsp & MemData_rsp);

  // Normal completion in the expiry cycle takes precedence over the abort.
  assign expire   = busy & (wdog == TIMEOUT_CNT) & ~data_done;
  assign addr_ack = (state == ADDR) & (MemAddress_rsp | expire);
  assign resp     = data_done | expire;
  assign rsp_data = expire ? ERR_DATA : MemReadData;

  assign sel_i = busy & ~grant_d;
  assign sel_d = busy &  grant_d;

  // Response steering: only the granted port ever sees a pulse or data.
  assign IMemAddress_rsp = sel_i & addr_ack;
  assign IMemData_rsp    = sel_i & resp;
  assign IMemReadData    = (sel_i & resp) ? rsp_data : 32'h0;
  assign DMemAddress_rsp = sel_d & addr_ack;
  assign DMemData_rsp    = sel_d & resp;
  assign DMemReadData    = (sel_d & resp) ? rsp_data : 32'h0;

  assign bus_err  = expire;
  assign err_addr = err_addr_q;

  assign MemAddress_vld = req_q.vld;
  assign MemAddress     = req_q.addr;
  assign MemOp          = req_q.op;
  assign MemOpSize      = req_q.size;
  assign MemWData_vld   = req_q.wvld;
  assign MemWriteData   = req_q.wdata;

  // Arbitration FSM: grant, present the request, wait for the memory, abort on watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_q        <= '0;
      grant_d      <= 1'b0;
      last_grant_d <= 1'b0;
      wdog         <= 16'h0;
      err_addr_q   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_d      <= pick_d;
            last_grant_d <= pick_d;
            wdog         <= 16'h0;
            state        <= ADDR;
            req_q.vld    <= 1'b1;
            if (pick_d) begin
              req_q.addr  <= DMemAddress;
              req_q.op    <= DMemOp;
              req_q.size  <= DMemOpSize;
              req_q.wvld  <= DMemWData_vld;
              req_q.wdata <= DMemWriteData;
            end else begin
              req_q.addr  <= IMemAddress;
              req_q.op    <= 1'b0;
              req_q.size  <= FETCH_SIZE;
              req_q.wvld  <= 1'b0;
              req_q.wdata <= 32'h0;
            end
          end
        end

        ADDR, DATA: begin
          wdog <= wdog + 16'd1;
          if (expire) begin
            err_addr_q <= req_q.addr;
            req_q      <= '0;
            state      <= IDLE;
          end else if (data_done) begin
            req_q <= '0;
            state <= IDLE;
          end else if ((state == ADDR) && MemAddress_rsp) begin
            req_q.vld  <= 1'b0;
            req_q.wvld <= 1'b0;
            state      <= DATA;
          end
        end

        default: begin
          req_q <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: two lanes, one per arbitration mode, each with its
// own memory model, requester drivers and expected-transaction scoreboard.
module tb_rv_mem_arbiter;

  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        op;
    logic [1:0]  size;
    logic        wvld;
    logic [31:0] wdata;
  } req_t;

  // kind: 0 normal, 1 address+data same cycle, 2 no data (abort in DATA),
  //       3 no answer at all (abort in ADDR)
  typedef struct {
    bit   port_d;
    req_t r;
    int   kind;
    bit   chk_lat;
  } txn_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0000_0013;
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic op, input logic [1:0] sz,
                                  input logic wv, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.op = op; r.size = sz; r.wvld = wv; r.wdata = wd;
    return r;
  endfunction

  function automatic req_t fetch_req(input logic [31:0] a);
    return mk_req(a, 1'b0, 2'b11, 1'b0, 32'h0);
  endfunction

  genvar k;
  for (k = 0; k < 2; k++) begin : g_lane
    localparam bit RR = (k == 1);

    logic        rst;
    logic        i_vld, i_arsp, i_drsp;
    logic [31:0] i_addr, i_rdata;
    logic        d_vld, d_op, d_wvld, d_arsp, d_drsp;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_vld, m_op, m_wvld, m_arsp, m_drsp;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        bus_err;
    logic [31:0] err_addr;

    bit   done;
    int   cyc, lat, cd, g_cyc, i_req_cyc, d_req_cyc;
    bit   last_d;
    txn_t exp_q[$];
    req_t iq[$];
    req_t dq[$];

    rv_mem_arbiter #(.ROUND_ROBIN(RR), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
      .clk(clk), .rst(rst),
      .IMemAddress_vld(i_vld), .IMemAddress(i_addr),
      .IMemAddress_rsp(i_arsp), .IMemData_rsp(i_drsp), .IMemReadData(i_rdata),
      .DMemAddress_vld(d_vld), .DMemAddress(d_addr), .DMemOp(d_op), .DMemOpSize(d_size),
      .DMemWData_vld(d_wvld), .DMemWriteData(d_wdata),
      .DMemAddress_rsp(d_arsp), .DMemData_rsp(d_drsp), .DMemReadData(d_rdata),
      .MemAddress_vld(m_vld), .MemAddress(m_addr), .MemOp(m_op), .MemOpSize(m_size),
      .MemWData_vld(m_wvld), .MemWriteData(m_wdata),
      .MemAddress_rsp(m_arsp), .MemData_rsp(m_drsp), .MemReadData(m_rdata),
      .bus_err(bus_err), .err_addr(err_addr)
    );

    task automatic add_exp(input bit pd, input req_t r, input int kind, input bit cl);
      txn_t t;
      t.port_d = pd; t.r = r; t.kind = kind; t.chk_lat = cl;
      exp_q.push_back(t);
      last_d = pd;
    endtask

    task automatic wait_done(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() + iq.size() + dq.size()) != 0 && n < 400) begin
        @(posedge clk);
        n++;
      end
      check_eq(tag, 64'(exp_q.size() + iq.size() + dq.size()), 64'd0);
      repeat (2) @(posedge clk);
    endtask

    // Memory model, scoreboard checker and requester drivers, once per cycle.
    initial begin
      txn_t        t;
      logic [31:0] cur_addr, exp_rd;
      bit          prev_vld, arsp_prev, popped;
      int          mode;
      i_vld = 0; i_addr = 0;
      d_vld = 0; d_addr = 0; d_op = 0; d_size = 0; d_wvld = 0; d_wdata = 0;
      m_arsp = 0; m_drsp = 0; m_rdata = 0;
      cyc = 0; cd = 0; g_cyc = 0; i_req_cyc = 0; d_req_cyc = 0;
      prev_vld = 0; arsp_prev = 0; cur_addr = 0; mode = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (arsp_prev) check_eq("mem_vld_drop", 64'(m_vld), 64'd0);
        arsp_prev = 0;
        m_arsp = 0; m_drsp = 0; m_rdata = $urandom;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin m_drsp = 1; m_rdata = mem_word(cur_addr); end
        end
        if (m_vld && !prev_vld) begin
          g_cyc = cyc;
          if (exp_q.size() == 0) check_eq("mem_unexpected", 64'(m_vld), 64'd0);
          else begin
            t = exp_q[0];
            check_eq("mem_addr",  64'(m_addr),  64'(t.r.addr));
            check_eq("mem_op",    64'(m_op),    64'(t.r.op));
            check_eq("mem_size",  64'(m_size),  64'(t.r.size));
            check_eq("mem_wvld",  64'(m_wvld),  64'(t.r.wvld));
            check_eq("mem_wdata", 64'(m_wdata), 64'(t.r.wdata));
            if (t.chk_lat)
              check_eq("grant_lat", 64'(cyc - (t.port_d ? d_req_cyc : i_req_cyc)), 64'd1);
            mode = t.kind;
            cur_addr = m_addr;
            if (mode != 3) begin m_arsp = 1; arsp_prev = 1; end
            if (mode == 1) begin m_drsp = 1; m_rdata = mem_word(m_addr); end
            if (mode == 0) cd = lat;
          end
        end
        prev_vld = m_vld;

        #1;
        if (i_arsp || d_arsp) begin
          check_eq("arsp_both", 64'(i_arsp & d_arsp), 64'd0);
          if (exp_q.size() == 0) check_eq("arsp_unexp", 64'({i_arsp, d_arsp}), 64'd0);
          else begin
            t = exp_q[0];
            check_eq("arsp_port", 64'(d_arsp), 64'(t.port_d));
            if (t.kind == 3) check_eq("tmo_addr_cyc", 64'(cyc - g_cyc), 64'(TMO));
          end
        end
        if (i_drsp || d_drsp) begin
          check_eq("drsp_both", 64'(i_drsp & d_drsp), 64'd0);
          if (exp_q.size() == 0) check_eq("drsp_unexp", 64'({i_drsp, d_drsp}), 64'd0);
          else begin
            t = exp_q.pop_front();
            exp_rd = (t.kind >= 2) ? ERR : mem_word(t.r.addr);
            check_eq("drsp_port", 64'(d_drsp), 64'(t.port_d));
            check_eq("rdata", 64'(t.port_d ? d_rdata : i_rdata), 64'(exp_rd));
            check_eq("other_rdata", 64'(t.port_d ? i_rdata : d_rdata), 64'd0);
            check_eq("bus_err", 64'(bus_err), 64'(t.kind >= 2));
            if (t.kind >= 2) check_eq("tmo_cyc", 64'(cyc - g_cyc), 64'(TMO));
            if (t.kind == 1) check_eq("same_cyc_arsp", 64'(t.port_d ? d_arsp : i_arsp), 64'd1);
          end
        end else begin
          check_eq("idle_rdata", {i_rdata, d_rdata}, 64'd0);
          check_eq("idle_bus_err", 64'(bus_err), 64'd0);
        end

        popped = 0;
        if (i_arsp && i_vld && iq.size() > 0) begin void'(iq.pop_front()); popped = 1; end
        if (iq.size() > 0) begin
          if (!i_vld || popped) i_req_cyc = cyc;
          i_vld = 1; i_addr = iq[0].addr;
        end else begin
          i_vld = 0; i_addr = 0;
        end
        popped = 0;
        if (d_arsp && d_vld && dq.size() > 0) begin void'(dq.pop_front()); popped = 1; end
        if (dq.size() > 0) begin
          if (!d_vld || popped) d_req_cyc = cyc;
          d_vld = 1; d_addr = dq[0].addr; d_op = dq[0].op; d_size = dq[0].size;
          d_wvld = dq[0].wvld; d_wdata = dq[0].wdata;
        end else begin
          d_vld = 0; d_addr = 0; d_op = 0; d_size = 0; d_wvld = 0; d_wdata = 0;
        end
      end
    end

    // Test sequence for this lane.
    initial begin
      req_t ri[4];
      req_t rd[4];
      req_t r;
      int   ii, id, n;
      bit   win_d;
      done = 0; rst = 1; lat = 2; last_d = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      check_eq("rst_ctrl", 64'({i_arsp, i_drsp, d_arsp, d_drsp, m_vld, m_op, m_size, m_wvld, bus_err}), 64'd0);
      check_eq("rst_mem", {m_addr, m_wdata}, 64'd0);
      check_eq("rst_err_addr", 64'(err_addr), 64'd0);
      @(posedge clk); #1 rst = 0;

      // Both ports hold four requests each from the start.
      @(posedge clk);
      for (int j = 0; j < 4; j++) begin
        rd[j] = mk_req(32'h0000_3000 + 32'(j * 4), (j % 2 == 1), 2'(j), (j % 2 == 1),
                       (j % 2 == 1) ? 32'h1111_0000 + 32'(j) : 32'h0);
        ri[j] = fetch_req(32'h0000_0100 + 32'(j * 4));
        dq.push_back(rd[j]);
        iq.push_back(ri[j]);
      end
      ii = 0; id = 0;
      while (ii < 4 || id < 4) begin
        win_d = (id < 4) && (ii >= 4 || !RR || !last_d);
        if (win_d) begin add_exp(1'b1, rd[id], 0, 1'b0); id++; end
        else       begin add_exp(1'b0, ri[ii], 0, 1'b0); ii++; end
      end
      wait_done("arb_done");

      // Single fetch from idle.
      r = fetch_req(32'h0000_0040);
      iq.push_back(r); add_exp(1'b0, r, 0, 1'b1);
      wait_done("fetch_done");

      // Data write.
      r = mk_req(32'h0000_1010, 1'b1, 2'b10, 1'b1, 32'hCAFE_F00D);
      dq.push_back(r); add_exp(1'b1, r, 0, 1'b1);
      wait_done("write_done");

      // Memory accepts the fetch address but never returns data.
      r = fetch_req(32'h0000_0200);
      iq.push_back(r); add_exp(1'b0, r, 2, 1'b0);
      wait_done("tmo_data_done");
      check_eq("err_addr_200", 64'(err_addr), 64'h200);
      r = mk_req(32'h0000_2000, 1'b0, 2'b01, 1'b0, 32'h0);
      dq.push_back(r); add_exp(1'b1, r, 0, 1'b1);
      wait_done("after_tmo_done");
      check_eq("err_addr_hold", 64'(err_addr), 64'h200);

      // Memory never accepts the data address.
      r = mk_req(32'h0000_0280, 1'b0, 2'b10, 1'b0, 32'h0);
      dq.push_back(r); add_exp(1'b1, r, 3, 1'b0);
      wait_done("tmo_addr_done");
      check_eq("err_addr_280", 64'(err_addr), 64'h280);

      // Address and data response in the same cycle, back to back.
      r = fetch_req(32'h0000_0500);
      iq.push_back(r); add_exp(1'b0, r, 1, 1'b1);
      wait_done("same_i_done");
      r = mk_req(32'h0000_0504, 1'b1, 2'b11, 1'b1, 32'h0BAD_F00D);
      dq.push_back(r); add_exp(1'b1, r, 1, 1'b1);
      wait_done("same_d_done");

      // Reset while waiting for data; the late response must be ignored.
      lat = 6;
      r = fetch_req(32'h0000_0300);
      iq.push_back(r); add_exp(1'b0, r, 0, 1'b0);
      n = 0;
      while (cd == 0 && n < 50) begin @(posedge clk); n++; end
      check_eq("reach_data", 64'(cd > 0), 64'd1);
      #1 rst = 1;
      exp_q.delete();
      last_d = 0;
      @(posedge clk); #1 rst = 0;
      @(negedge clk); #2;
      check_eq("midrst_ctrl", 64'({i_arsp, i_drsp, d_arsp, d_drsp, m_vld, m_op, m_size, m_wvld, bus_err}), 64'd0);
      check_eq("midrst_rdata", {i_rdata, d_rdata}, 64'd0);
      check_eq("midrst_mem", {m_addr, m_wdata}, 64'd0);
      check_eq("midrst_err_addr", 64'(err_addr), 64'd0);
      n = 0;
      while (cd != 0 && n < 20) begin @(posedge clk); n++; end
      check_eq("late_rsp_gone", 64'(cd), 64'd0);
      repeat (2) @(posedge clk);
      lat = 2;
      r = fetch_req(32'h0000_0344);
      iq.push_back(r); add_exp(1'b0, r, 0, 1'b1);
      wait_done("post_rst_done");
      done = 1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g_lane[0].done && g_lane[1].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check_eq("lanes_done", 64'({g_lane[0].done, g_lane[1].done}), 64'd3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
